// File: rtl/mac_result_drain.sv
// Result drain buffer for the MAC pipeline: credit-based issue gating plus FWFT result FIFO.
// Optional NaN head flag via `define MAC_DRAIN_NAN_FLAG_EN (adds out_nan).
module mac_result_drain #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 14
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     issue_req,
    output logic                     issue_grant,
    input  logic                     res_valid,
    input  logic [WIDTH-1:0]         res_data,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   credits,
`ifdef MAC_DRAIN_NAN_FLAG_EN
    output logic                     out_nan,
`endif
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < LATENCY + 2)) begin : g_cfg_err
        $error("mac_result_drain: DEPTH must be a power of two >= LATENCY+2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [AW:0]      r_cnt;
    logic [AW:0]      r_cred;
    logic             r_ovf;

    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_drop;

    assign w_full      = (r_cnt == FULL);
    assign out_valid   = (r_cnt != '0);
    assign out_data    = r_mem[r_rd];
    assign w_pop       = !reset && out_valid && out_ready;
    assign w_push      = !reset && res_valid && (!w_full || w_pop);
    assign w_drop      = !reset && res_valid && w_full && !w_pop;
    assign issue_grant = !reset && issue_req && (r_cred != '0);
    assign credits     = r_cred;
    assign overflow    = r_ovf;

`ifdef MAC_DRAIN_NAN_FLAG_EN
    assign out_nan = out_valid && (out_data[30:23] == 8'hFF) && (out_data[22:0] != '0);
`endif

    // Storage has no reset; occupancy is tracked solely by r_cnt.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr] <= res_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_cnt  <= '0;
            r_cred <= FULL;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
            // Pops of words pushed without a credit must not lift credits past DEPTH.
            unique case ({issue_grant, w_pop})
                2'b10:   r_cred <= r_cred - (AW+1)'(1);
                2'b01:   r_cred <= (r_cred == FULL) ? r_cred : r_cred + (AW+1)'(1);
                default: r_cred <= r_cred;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_result_drain.sv
// Randomized and directed bench for mac_result_drain against a queue-based reference model.
// Build with +define+MAC_DRAIN_NAN_FLAG_EN to exercise the NaN flag.
module tb_mac_result_drain;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int L  = 14;
    localparam int MP = L - 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          issue_req;
    logic          issue_grant;
    logic          res_valid;
    logic [W-1:0]  res_data;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [4:0]    credits;
    logic          overflow;
`ifdef MAC_DRAIN_NAN_FLAG_EN
    logic          out_nan;
`endif

    mac_result_drain #(.WIDTH(W), .DEPTH(D), .LATENCY(L)) dut (
        .clock       (clock),
        .reset       (reset),
        .issue_req   (issue_req),
        .issue_grant (issue_grant),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .credits     (credits),
`ifdef MAC_DRAIN_NAN_FLAG_EN
        .out_nan     (out_nan),
`endif
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    int          n_chk;
    int          n_fail;
    logic [31:0] q[$];
    int          m_cred;
    bit          m_ovf;
    bit          mac_en;
    bit          mv [MP+1];
    logic [31:0] md [MP+1];
    int          grants;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] v);
        return (((v >> 23) & 32'hFF) == 32'hFF) && ((v & 32'h7F_FFFF) != 0);
    endfunction

    // One clock cycle: check grant, update model at the edge, check state after it.
    task automatic tick();
        bit g;
        bit p;
        #1;
        g = !reset && issue_req && (m_cred != 0);
        check("grant", issue_grant, g);
        if (issue_grant) grants++;
        @(posedge clock);
        p = !reset && out_ready && (q.size() != 0);
        if (reset) begin
            q.delete();
            m_cred = D;
            m_ovf  = 0;
        end else begin
            m_cred = m_cred - int'(g) + int'(p);
            if (m_cred > D) m_cred = D;
            if (p) void'(q.pop_front());
            if (res_valid) begin
                if (q.size() < D) q.push_back(res_data);
                else m_ovf = 1;
            end
        end
        for (int i = MP; i > 0; i--) begin
            mv[i] = mv[i-1];
            md[i] = md[i-1];
        end
        mv[0] = g && !reset;
        md[0] = $urandom;
        @(negedge clock);
        if (mac_en) begin
            res_valid = mv[MP];
            res_data  = md[MP];
        end
        check("out_valid", out_valid, q.size() != 0);
        check("credits", credits, m_cred);
        check("overflow", overflow, m_ovf);
        if (q.size() != 0) check("out_data", out_data, q[0]);
`ifdef MAC_DRAIN_NAN_FLAG_EN
        check("out_nan", out_nan, (q.size() != 0) && is_nan(q[0]));
`endif
    endtask

    task automatic do_reset();
        reset     = 1;
        res_valid = 0;
        issue_req = 0;
        out_ready = 0;
        mac_en    = 0;
        for (int i = 0; i <= MP; i++) mv[i] = 0;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            res_valid = 1;
            res_data  = $urandom;
            tick();
        end
        res_valid = 0;
    endtask

    logic [31:0] w0;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        m_cred = D;
        m_ovf  = 0;
        grants = 0;
        mac_en = 0;
        for (int i = 0; i <= MP; i++) mv[i] = 0;

        // Reset with all inputs active
        reset     = 1;
        res_valid = 1;
        res_data  = 32'h1234_5678;
        issue_req = 1;
        out_ready = 1;
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_cred", credits, 16);
        check("rst_ovf", overflow, 0);
        reset     = 0;
        res_valid = 0;
        issue_req = 0;
        out_ready = 0;
        tick();
        check("rst_empty", out_valid, 0);

        // Throughput with a 14-cycle MAC
        do_reset();
        mac_en    = 1;
        grants    = 0;
        issue_req = 1;
        out_ready = 1;
        repeat (60) tick();
        check("tput_grants", grants, 60);
        check("tput_cred", credits, 2);
        check("tput_ovf", overflow, 0);
        issue_req = 0;
        repeat (20) tick();
        check("tput_drain", out_valid, 0);
        mac_en    = 0;
        res_valid = 0;

        // Backpressure
        do_reset();
        grants    = 0;
        issue_req = 1;
        out_ready = 0;
        repeat (20) tick();
        check("bp_grants", grants, 16);
        check("bp_cred", credits, 0);
        #1;
        check("bp_grant_low", issue_grant, 0);
        res_valid = 1;
        res_data  = $urandom;
        tick();
        res_valid = 0;
        out_ready = 1;
        tick();
        out_ready = 0;
        grants    = 0;
        repeat (4) tick();
        check("bp_regrant", grants, 1);

        // Forced overflow
        do_reset();
        res_valid = 1;
        res_data  = $urandom;
        w0        = res_data;
        tick();
        push_n(15);
        res_valid = 1;
        res_data  = 32'h3F80_0000;
        tick();
        res_valid = 0;
        check("ovf_set", overflow, 1);
        check("ovf_head", out_data, w0);
        out_ready = 1;
        repeat (17) tick();
        check("ovf_drained", out_valid, 0);
        check("ovf_sticky", overflow, 1);
        out_ready = 0;

        // Full buffer push and pop in the same cycle
        do_reset();
        push_n(16);
        res_valid = 1;
        res_data  = 32'h4000_0000;
        out_ready = 1;
        tick();
        res_valid = 0;
        check("full_ovf", overflow, 0);
        repeat (15) tick();
        check("full_tail", out_data, 32'h4000_0000);
        tick();
        check("full_count16", out_valid, 0);
        out_ready = 0;

`ifdef MAC_DRAIN_NAN_FLAG_EN
        do_reset();
        res_valid = 1;
        res_data  = 32'h7FC0_0000;
        tick();
        res_data  = 32'h7F80_0000;
        tick();
        res_valid = 0;
        check("nan_qnan", out_nan, 1);
        out_ready = 1;
        tick();
        out_ready = 0;
        check("nan_inf", out_nan, 0);
`endif

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 499) == 0);
            issue_req = $urandom_range(0, 1);
            res_valid = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0:       res_data = 32'h7FC0_0000 | ($urandom & 32'h3F_FFFF);
                1:       res_data = 32'h7F80_0000;
                default: res_data = $urandom;
            endcase
            tick();
        end
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_result_drain.md
MAC_RESULT_DRAIN -- requirements
Module: mac_result_drain

Interface
REQ-001 SHALL have parameter WIDTH, default 32, result word width (IEEE-754 single).
REQ-002 SHALL have parameter DEPTH, default 16, result storage entries; power of two, >= LATENCY+2.
REQ-003 SHALL have parameter LATENCY, default 14, MAC pipeline issue-to-result cycles, informational only.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port issue_req  input  1  upstream requests to issue one A/B operand pair into the MAC.
REQ-007 SHALL have port issue_grant  output  1  issue accepted this cycle; combinational.
REQ-008 SHALL have port res_valid  input  1  result word present at MAC pipeline tail.
REQ-009 SHALL have port res_data  input  WIDTH  result word from MAC pipeline tail.
REQ-010 SHALL have port out_valid  output  1  head entry available to consumer.
REQ-011 SHALL have port out_data  output  WIDTH  head entry data.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-013 SHALL have port credits  output  log2(DEPTH)+1  free result slots not yet promised to in-flight issues.
REQ-014 SHALL have port overflow  output  1  sticky error: result arrived with storage full.

Function
REQ-015 SHALL assert issue_grant = issue_req AND (credits != 0).
REQ-016 SHALL decrement credits on grant, increment on pop (out_valid AND out_ready); grant and pop in the same cycle leave credits unchanged.
REQ-017 SHALL never let credits exceed DEPTH or fall below 0.
REQ-018 SHALL store results in a circular buffer with rd_ptr, wr_ptr (log2(DEPTH) bits, wrapping DEPTH-1 -> 0) and count (0..DEPTH).
REQ-019 SHALL push res_data on every res_valid cycle unless count == DEPTH with no pop that cycle.
REQ-020 SHALL, on push with count == DEPTH and simultaneous pop, accept the push; count unchanged.
REQ-021 SHALL, on push with count == DEPTH and no pop, drop the word, leave pointers unchanged, set overflow to 1 on the next edge.
REQ-022 SHALL drive out_valid = (count != 0) and out_data = mem[rd_ptr] (first-word-fall-through).
REQ-023 SHALL give latency of exactly 1 cycle: res_valid at edge N with empty buffer -> out_valid high after edge N; no same-cycle bypass.
REQ-024 SHALL not pop when out_valid is 0, regardless of out_ready.
REQ-025 SHALL hold out_data stable while out_valid AND NOT out_ready.
REQ-026 SHALL preserve result order: pop order equals push order.
REQ-027 SHALL keep overflow high until reset.

Reset
REQ-028 SHALL, when reset is high at a rising edge, clear rd_ptr, wr_ptr, count and overflow to 0 and set credits to DEPTH.
REQ-029 SHALL hold out_valid at 0 the cycle after reset and ignore res_valid, issue_req and out_ready during reset cycles (issue_grant low).
REQ-030 SHALL require the MAC pipeline to be reset on the same edge; results in flight at reset are discarded by the pipeline, not this block.

Configuration
REQ-031 SHALL, with macro MAC_DRAIN_NAN_FLAG_EN defined, add output out_nan (1 bit): high when out_valid and out_data[30:23] == 8'hFF and out_data[22:0] != 0; reset value 0.
REQ-032 SHALL, without MAC_DRAIN_NAN_FLAG_EN, omit out_nan; all other behaviour identical.

Verification
REQ-033 SHALL verify reset: reset high 2 cycles with res_valid=1 -> count 0, out_valid 0, credits 16, overflow 0.
REQ-034 SHALL verify throughput: issue_req held 1, out_ready held 1, results returned 14 cycles after each grant -> grant every cycle, credits settle at 2, no overflow, data order preserved.
REQ-035 SHALL verify backpressure: out_ready 0, issue_req 1 -> exactly 16 grants then issue_grant 0 with credits 0; one pop -> one further grant.
REQ-036 SHALL verify forced overflow: push 16 words (out_ready 0) bypassing credits, push 0x3F800000 -> word dropped, overflow 1, head still first word.
REQ-037 SHALL verify full push+pop: count 16, res_valid with 0x40000000 and out_ready 1 same cycle -> count stays 16, 0x40000000 at tail, overflow 0.
REQ-038 SHALL verify NaN flag (macro defined): push 0x7FC00000 then 0x7F800000 -> out_nan 1 then 0.
